// File: rtl/cmdin_dispatcher_if.sv
// cmdin_dispatcher_if -- bundle of the dispatcher's bus-facing signals.
//   cmdin_queue_* : BRAM port onto the command-in queue (byte address, 64-bit data)
//   cmdin_out_*   : AXI-stream style command output (tvalid/tready/tdest/tdata/tlast)
//   finish_*      : one-cycle pulse from an accelerator that finished its command
// master = dispatcher side, slave = BRAM/stream sink/accelerator side.
interface cmdin_dispatcher_if #(
  parameter int MAX_ACCS = 16
);
  localparam int DEST_W = (MAX_ACCS > 1) ? $clog2(MAX_ACCS) : 1;

  logic              cmdin_queue_en;
  logic [7:0]        cmdin_queue_we;
  logic [31:0]       cmdin_queue_addr;
  logic [63:0]       cmdin_queue_din;
  logic [63:0]       cmdin_queue_dout;

  logic              cmdin_out_tvalid;
  logic              cmdin_out_tready;
  logic [DEST_W-1:0] cmdin_out_tdest;
  logic [63:0]       cmdin_out_tdata;
  logic              cmdin_out_tlast;

  logic              finish_valid;
  logic [DEST_W-1:0] finish_id;

  modport master (
    output cmdin_queue_en, cmdin_queue_we, cmdin_queue_addr, cmdin_queue_din,
    input  cmdin_queue_dout,
    output cmdin_out_tvalid, cmdin_out_tdest, cmdin_out_tdata, cmdin_out_tlast,
    input  cmdin_out_tready,
    input  finish_valid, finish_id
  );

  modport slave (
    input  cmdin_queue_en, cmdin_queue_we, cmdin_queue_addr, cmdin_queue_din,
    output cmdin_queue_dout,
    input  cmdin_out_tvalid, cmdin_out_tdest, cmdin_out_tdata, cmdin_out_tlast,
    output cmdin_out_tready,
    output finish_valid, finish_id
  );
endinterface

// File: rtl/cmdin_dispatcher.sv
// cmdin_dispatcher -- pulls commands out of a BRAM holding one circular
// subqueue per accelerator and streams them out, one command at a time.
//   aclk            : clock, rising edge
//   ps_rst          : synchronous active-high reset
//   cmdin_queue_clk : aclk passed through to the BRAM
//   cmdin_queue_rst : ps_rst passed through to the BRAM
//   bus             : BRAM port, command stream output, finish pulses
//   acc_busy        : per-accelerator busy mask (set on dispatch, cleared on finish)
//   error           : sticky flag, a header announced more payload than fits
// Subqueue a occupies entries a*LEN .. a*LEN+LEN-1. An entry whose top byte is
// 0x80 is a header; its low byte N gives the payload word count that follows.
module cmdin_dispatcher #(
  parameter int MAX_ACCS           = 16,
  parameter int CMDIN_SUBQUEUE_LEN = 64
) (
  input  logic                aclk,
  input  logic                ps_rst,
  output logic                cmdin_queue_clk,
  output logic                cmdin_queue_rst,
  cmdin_dispatcher_if.master  bus,
  output logic [MAX_ACCS-1:0] acc_busy,
  output logic                error
);
  localparam int LEN = CMDIN_SUBQUEUE_LEN;
  localparam int AW  = (MAX_ACCS > 1) ? $clog2(MAX_ACCS) : 1;
  localparam int PW  = (LEN > 1) ? $clog2(LEN) : 1;

  typedef enum logic [2:0] {
    S_SCAN, S_RD_HDR, S_CHK_HDR, S_RD_PAY, S_SEND, S_CLR
  } state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       cur_acc;
  logic [AW-1:0]       rr;
  logic [PW-1:0]       rd_ptr [MAX_ACCS];
  logic [7:0]          hdr_n;
  logic [7:0]          beat_k;
  logic                bad_q;
  logic                tvalid_q, tlast_q;
  logic [63:0]         tdata_q;
  logic [AW-1:0]       tdest_q;
  logic [MAX_ACCS-1:0] busy_d;

  logic                scan_found;
  logic [AW-1:0]       scan_pick;
  logic                hdr_valid, hdr_oversize, xfer;
  logic [7:0]          hdr_len;
  logic                q_en;
  logic [7:0]          q_we;
  logic [31:0]         q_addr;

  function automatic logic [AW-1:0] next_acc(input logic [AW-1:0] a);
    return (int'(a) == MAX_ACCS - 1) ? '0 : a + 1'b1;
  endfunction

  function automatic logic [AW-1:0] rot(input logic [AW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= MAX_ACCS) s = s - MAX_ACCS;
    return AW'(s);
  endfunction

  function automatic logic [31:0] entry_addr(input logic [AW-1:0] a, input logic [PW-1:0] ptr);
    return (32'(a) * 32'(LEN) + 32'(ptr)) << 3;
  endfunction

  assign cmdin_queue_clk = aclk;
  assign cmdin_queue_rst = ps_rst;

  // Header decode straight off the BRAM read data (valid in CHK_HDR).
  assign hdr_valid    = (bus.cmdin_queue_dout[63:56] == 8'h80);
  assign hdr_len      = bus.cmdin_queue_dout[7:0];
  assign hdr_oversize = (32'(hdr_len) > 32'(LEN - 1));
  assign xfer         = tvalid_q & bus.cmdin_out_tready;

  // First idle accelerator at or after rr, wrapping.
  always_comb begin
    scan_found = 1'b0;
    scan_pick  = '0;
    for (int i = 0; i < MAX_ACCS; i++) begin
      if (!scan_found && !acc_busy[rot(rr, i)]) begin
        scan_found = 1'b1;
        scan_pick  = rot(rr, i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_SCAN:    if (scan_found) state_d = S_RD_HDR;
      S_RD_HDR:  state_d = S_CHK_HDR;
      S_CHK_HDR: begin
        if (!hdr_valid)       state_d = S_SCAN;
        else if (hdr_oversize) state_d = S_CLR;
        else                   state_d = S_SEND;
      end
      S_SEND:    if (xfer) state_d = (beat_k == hdr_n) ? S_CLR : S_RD_PAY;
      S_RD_PAY:  state_d = S_SEND;
      S_CLR:     state_d = S_SCAN;
      default:   state_d = S_SCAN;
    endcase
  end

  // BRAM port is decoded from state; gated by reset so an aborted CLR
  // never reaches the memory.
  always_comb begin
    q_en   = 1'b0;
    q_we   = '0;
    q_addr = '0;
    if (!ps_rst) begin
      case (state_q)
        S_RD_HDR: begin
          q_en   = 1'b1;
          q_addr = entry_addr(cur_acc, rd_ptr[cur_acc]);
        end
        S_RD_PAY: begin
          // beat_k already counts the word being fetched; wraps inside the subqueue
          q_en   = 1'b1;
          q_addr = entry_addr(cur_acc, rd_ptr[cur_acc] + PW'(beat_k));
        end
        S_CLR: begin
          q_en   = 1'b1;
          q_we   = 8'hFF;
          q_addr = entry_addr(cur_acc, rd_ptr[cur_acc]);
        end
        default: ;
      endcase
    end
  end

  assign bus.cmdin_queue_en   = q_en;
  assign bus.cmdin_queue_we   = q_we;
  assign bus.cmdin_queue_addr = q_addr;
  assign bus.cmdin_queue_din  = '0;

  // Finish clears, dispatch sets; the set is applied last so it wins.
  always_comb begin
    busy_d = acc_busy;
    if (bus.finish_valid && (int'(bus.finish_id) < MAX_ACCS))
      busy_d[bus.finish_id] = 1'b0;
    if (state_q == S_CLR && !bad_q)
      busy_d[cur_acc] = 1'b1;
  end

  always_ff @(posedge aclk) begin
    if (ps_rst) state_q <= S_SCAN;
    else        state_q <= state_d;
  end

  always_ff @(posedge aclk) begin
    if (ps_rst) begin
      cur_acc  <= '0;
      rr       <= '0;
      hdr_n    <= '0;
      beat_k   <= '0;
      bad_q    <= 1'b0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tdata_q  <= '0;
      tdest_q  <= '0;
      acc_busy <= '0;
      error    <= 1'b0;
      for (int i = 0; i < MAX_ACCS; i++) rd_ptr[i] <= '0;
    end else begin
      acc_busy <= busy_d;
      case (state_q)
        S_SCAN: if (scan_found) cur_acc <= scan_pick;
        S_CHK_HDR: begin
          hdr_n  <= hdr_len;
          beat_k <= '0;
          bad_q  <= hdr_valid & hdr_oversize;
          if (!hdr_valid) begin
            rr <= next_acc(cur_acc);
          end else if (!hdr_oversize) begin
            tvalid_q <= 1'b1;
            tdata_q  <= bus.cmdin_queue_dout;
            tdest_q  <= cur_acc;
            tlast_q  <= (hdr_len == 8'd0);
          end
        end
        S_SEND: begin
          if (!tvalid_q) begin
            // arrived from RD_PAY: read data is on dout this cycle
            tvalid_q <= 1'b1;
            tdata_q  <= bus.cmdin_queue_dout;
            tlast_q  <= (beat_k == hdr_n);
          end else if (xfer) begin
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            beat_k   <= beat_k + 8'd1;
          end
        end
        S_CLR: begin
          rd_ptr[cur_acc] <= rd_ptr[cur_acc] + (bad_q ? PW'(1) : PW'(32'(hdr_n) + 1));
          rr <= next_acc(cur_acc);
          if (bad_q) error <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.cmdin_out_tvalid = tvalid_q;
  assign bus.cmdin_out_tdata  = tdata_q;
  assign bus.cmdin_out_tdest  = tdest_q;
  assign bus.cmdin_out_tlast  = tlast_q;
endmodule

// File: tb/tb_cmdin_dispatcher.sv
module tb_cmdin_dispatcher;
  localparam int NA  = 16;
  localparam int LEN = 64;

  logic          aclk = 1'b0;
  logic          ps_rst = 1'b1;
  logic          q_clk, q_rst;
  logic [NA-1:0] acc_busy;
  logic          error;

  cmdin_dispatcher_if #(.MAX_ACCS(NA)) bus();

  cmdin_dispatcher #(.MAX_ACCS(NA), .CMDIN_SUBQUEUE_LEN(LEN)) dut (
    .aclk(aclk), .ps_rst(ps_rst),
    .cmdin_queue_clk(q_clk), .cmdin_queue_rst(q_rst),
    .bus(bus), .acc_busy(acc_busy), .error(error)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [3:0]  dest;
    logic [63:0] data;
    logic        last;
  } beat_t;

  beat_t sb[$];
  int    checks = 0, errs = 0;
  int    beats_seen = 0, beats_pushed = 0, rd_cnt = 0;

  logic [63:0] mem [NA*LEN] = '{default: '0};
  logic        hw_en = 1'b0;
  int          hw_idx = 0;
  logic [63:0] hw_data = '0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // BRAM model: one-cycle read latency, byte-write, plus a host write port.
  always @(posedge aclk) begin
    if (hw_en) mem[hw_idx] <= hw_data;
    if (bus.cmdin_queue_en === 1'b1) begin
      if (bus.cmdin_queue_we != 8'h00) begin
        for (int b = 0; b < 8; b++)
          if (bus.cmdin_queue_we[b])
            mem[int'(bus.cmdin_queue_addr >> 3)][b*8 +: 8] <= bus.cmdin_queue_din[b*8 +: 8];
      end else begin
        bus.cmdin_queue_dout <= mem[int'(bus.cmdin_queue_addr >> 3)];
        rd_cnt++;
      end
    end
  end

  // Stream monitor: pops on each transfer, checks hold while stalled.
  beat_t       exp_b;
  logic        stall_prev = 1'b0;
  logic [63:0] stall_data;
  logic [3:0]  stall_dest;
  logic        stall_last;

  always @(negedge aclk) begin
    if (ps_rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_valid", 64'(bus.cmdin_out_tvalid), 64'(1));
        chk("stall_data",  bus.cmdin_out_tdata, stall_data);
        chk("stall_dest",  64'(bus.cmdin_out_tdest), 64'(stall_dest));
        chk("stall_last",  64'(bus.cmdin_out_tlast), 64'(stall_last));
      end
      if (bus.cmdin_out_tvalid === 1'b1 && bus.cmdin_out_tready === 1'b1) begin
        beats_seen++;
        if (sb.size() > 0) begin
          exp_b = sb.pop_front();
          chk("beat_data", bus.cmdin_out_tdata, exp_b.data);
          chk("beat_dest", 64'(bus.cmdin_out_tdest), 64'(exp_b.dest));
          chk("beat_last", 64'(bus.cmdin_out_tlast), 64'(exp_b.last));
        end
      end
      stall_prev = (bus.cmdin_out_tvalid === 1'b1) && (bus.cmdin_out_tready !== 1'b1);
      stall_data = bus.cmdin_out_tdata;
      stall_dest = bus.cmdin_out_tdest;
      stall_last = bus.cmdin_out_tlast;
    end
  end

  function automatic logic [63:0] mk_hdr(input logic [7:0] n, input logic [15:0] tag);
    return {8'h80, tag, 32'h0, n};
  endfunction

  function automatic logic [63:0] pay(input int acc, input int k);
    return {8'h5A, 8'(acc), 40'(k), 8'h33};
  endfunction

  task automatic put(input int idx, input logic [63:0] d);
    hw_idx = idx; hw_data = d; hw_en = 1'b1;
    @(posedge aclk); #1;
    hw_en = 1'b0;
  endtask

  task automatic push(input int dest, input logic [63:0] d, input logic last);
    beat_t b;
    b.dest = 4'(dest); b.data = d; b.last = last;
    sb.push_back(b);
    beats_pushed++;
  endtask

  task automatic fin(input int id);
    bus.finish_id = 4'(id); bus.finish_valid = 1'b1;
    @(posedge aclk); #1;
    bus.finish_valid = 1'b0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic wait_drain(input int bound);
    int n = 0;
    while (sb.size() != 0 && n < bound) begin
      @(posedge aclk); #1; n++;
    end
    chk("drain", 64'(sb.size()), 64'(0));
    cyc(4);
  endtask

  task automatic wait_tvalid(input int bound);
    int n = 0;
    while (bus.cmdin_out_tvalid !== 1'b1 && n < bound) begin
      @(posedge aclk); #1; n++;
    end
    chk("tvalid_wait", 64'(bus.cmdin_out_tvalid), 64'(1));
  endtask

  task automatic one_beat();
    bus.cmdin_out_tready = 1'b1;
    @(posedge aclk); #1;
    bus.cmdin_out_tready = 1'b0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_tvalid"}, 64'(bus.cmdin_out_tvalid), 64'(0));
    chk({tag, "_tlast"},  64'(bus.cmdin_out_tlast),  64'(0));
    chk({tag, "_tdata"},  bus.cmdin_out_tdata, 64'(0));
    chk({tag, "_tdest"},  64'(bus.cmdin_out_tdest),  64'(0));
    chk({tag, "_en"},     64'(bus.cmdin_queue_en),   64'(0));
    chk({tag, "_we"},     64'(bus.cmdin_queue_we),   64'(0));
    chk({tag, "_addr"},   64'(bus.cmdin_queue_addr), 64'(0));
    chk({tag, "_din"},    bus.cmdin_queue_din, 64'(0));
    chk({tag, "_busy"},   64'(acc_busy), 64'(0));
    chk({tag, "_error"},  64'(error), 64'(0));
  endtask

  int          rc0;
  logic [63:0] h;

  initial begin
    bus.cmdin_out_tready = 1'b0;
    bus.finish_valid     = 1'b0;
    bus.finish_id        = '0;

    // reset state
    cyc(3);
    chk_reset_outs("rst");
    chk("rst_qrst", 64'(q_rst), 64'(1));
    ps_rst = 1'b0;
    cyc(1);

    // basic 3-beat command on acc 2
    bus.cmdin_out_tready = 1'b1;
    put(129, 64'hAAAA_0000_0000_000A);
    put(130, 64'hBBBB_0000_0000_000B);
    push(2, 64'h8000_0000_0000_0002, 1'b0);
    push(2, 64'hAAAA_0000_0000_000A, 1'b0);
    push(2, 64'hBBBB_0000_0000_000B, 1'b1);
    put(128, 64'h8000_0000_0000_0002);
    wait_drain(400);
    chk("t1_hdr_clr", mem[128], 64'(0));
    chk("t1_rd2", 64'(dut.rd_ptr[2]), 64'(3));
    chk("t1_busy", 64'(acc_busy), 64'h0004);
    chk("t1_beats", 64'(beats_seen), 64'(beats_pushed));
    fin(7);
    chk("fin_idle_ignored", 64'(acc_busy), 64'h0004);
    fin(2);
    chk("fin_clear", 64'(acc_busy), 64'(0));

    // acc 5: advance rd to 62, then a command that wraps
    for (int k = 1; k <= 61; k++) put(320 + k, pay(5, k));
    h = mk_hdr(8'd61, 16'h0501);
    push(5, h, 1'b0);
    for (int k = 1; k <= 61; k++) push(5, pay(5, k), k == 61);
    put(320, h);
    wait_drain(2000);
    chk("t2_rd5_a", 64'(dut.rd_ptr[5]), 64'(62));
    chk("t2_busy_a", 64'(acc_busy), 64'h0020);
    put(383, pay(5, 101));
    put(320, pay(5, 102));
    put(321, pay(5, 103));
    h = mk_hdr(8'd3, 16'h0502);
    push(5, h, 1'b0);
    push(5, pay(5, 101), 1'b0);
    push(5, pay(5, 102), 1'b0);
    push(5, pay(5, 103), 1'b1);
    put(382, h);
    cyc(20);
    chk("t2_busy_no_disp", 64'(bus.cmdin_out_tvalid), 64'(0));
    fin(5);
    wait_drain(400);
    chk("t2_rd5_b", 64'(dut.rd_ptr[5]), 64'(2));
    chk("t2_beats", 64'(beats_seen), 64'(beats_pushed));
    fin(5);

    // round-robin between acc 0 and acc 1
    bus.cmdin_out_tready = 1'b0;
    push(0, mk_hdr(8'd0, 16'h0A01), 1'b1);
    put(0, mk_hdr(8'd0, 16'h0A01));
    wait_tvalid(100);
    push(1, mk_hdr(8'd0, 16'h0B01), 1'b1);
    put(64, mk_hdr(8'd0, 16'h0B01));
    bus.cmdin_out_tready = 1'b1;
    wait_drain(200);
    chk("t3_busy_a", 64'(acc_busy), 64'h0003);
    bus.cmdin_out_tready = 1'b0;
    push(0, mk_hdr(8'd0, 16'h0A02), 1'b1);
    push(1, mk_hdr(8'd0, 16'h0B02), 1'b1);
    put(1, mk_hdr(8'd0, 16'h0A02));
    put(65, mk_hdr(8'd0, 16'h0B02));
    cyc(20);
    chk("t3_busy_no_disp", 64'(bus.cmdin_out_tvalid), 64'(0));
    fin(0);
    wait_tvalid(100);
    fin(1);
    bus.cmdin_out_tready = 1'b1;
    wait_drain(200);
    chk("t3_busy_b", 64'(acc_busy), 64'h0003);
    chk("t3_beats", 64'(beats_seen), 64'(beats_pushed));
    fin(0);
    fin(1);

    // backpressure during payload on acc 3
    bus.cmdin_out_tready = 1'b0;
    for (int k = 1; k <= 3; k++) put(192 + k, pay(3, k));
    h = mk_hdr(8'd3, 16'h0301);
    push(3, h, 1'b0);
    for (int k = 1; k <= 3; k++) push(3, pay(3, k), k == 3);
    put(192, h);
    wait_tvalid(100);
    one_beat();
    wait_tvalid(20);
    rc0 = rd_cnt;
    cyc(5);
    chk("t4_stall_reads", 64'(rd_cnt - rc0), 64'(0));
    bus.cmdin_out_tready = 1'b1;
    wait_drain(200);
    chk("t4_beats", 64'(beats_seen), 64'(beats_pushed));
    chk("t4_busy", 64'(acc_busy), 64'h0008);
    fin(3);

    // oversize header on acc 4
    put(256, 64'h8000_0000_0000_0040);
    cyc(80);
    chk("t5_error", 64'(error), 64'(1));
    chk("t5_hdr_clr", mem[256], 64'(0));
    chk("t5_rd4", 64'(dut.rd_ptr[4]), 64'(1));
    chk("t5_busy", 64'(acc_busy), 64'(0));
    chk("t5_beats", 64'(beats_seen), 64'(beats_pushed));

    // reset during beat 2 of a 4-word command on acc 6
    bus.cmdin_out_tready = 1'b0;
    for (int k = 1; k <= 3; k++) put(384 + k, pay(6, k));
    h = mk_hdr(8'd3, 16'h0601);
    push(6, h, 1'b0);
    put(384, h);
    wait_tvalid(100);
    one_beat();
    wait_tvalid(20);
    chk("t6_error_sticky", 64'(error), 64'(1));
    ps_rst = 1'b1;
    cyc(1);
    chk_reset_outs("t6");
    cyc(1);
    chk("t6_no_clr", mem[384], h);
    ps_rst = 1'b0;
    chk("t6_rd6", 64'(dut.rd_ptr[6]), 64'(0));
    push(6, h, 1'b0);
    for (int k = 1; k <= 3; k++) push(6, pay(6, k), k == 3);
    bus.cmdin_out_tready = 1'b1;
    wait_drain(300);
    chk("t6_beats", 64'(beats_seen), 64'(beats_pushed));
    chk("t6_rd6_end", 64'(dut.rd_ptr[6]), 64'(4));
    chk("t6_busy", 64'(acc_busy), 64'h0040);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
